// File: rtl/fpalu_console.sv
// Operator console for the FPALU: debounced keys, switch-driven operand capture,
// start/done handshake with timeout, and a registered display word.
//
// state | meaning
// IDLE  | waiting for an execute key event
// ISSUE | oalu_start high for this cycle, wait timer armed
// WAIT  | waiting for ialu_done or wait timer expiry

module fpalu_console #(
    parameter int DATA_W    = 32,
    parameter int SW_W      = 10,
    parameter int OP_W      = 4,
    parameter int LOAD_MODE = 0,
    parameter int DEBOUNCE  = 500000,
    parameter int TIMEOUT   = 255
) (
    input  logic              iclock,
    input  logic              ireset,
    input  logic [3:0]        ikey,
    input  logic [SW_W-1:0]   isw,
    input  logic [OP_W-1:0]   icontrol,
    output logic [DATA_W-1:0] oalu_a,
    output logic [DATA_W-1:0] oalu_b,
    output logic [OP_W-1:0]   oalu_ctrl,
    output logic              oalu_start,
    input  logic              ialu_done,
    input  logic [DATA_W-1:0] ialu_result,
    input  logic [4:0]        ialu_flags,
    output logic [DATA_W-1:0] oresult,
    output logic [4:0]        oflags,
    output logic [DATA_W-1:0] odisp,
    output logic [1:0]        oview,
    output logic              osel,
    output logic              obusy,
    output logic              otimeout
);

    localparam int DB_W = $clog2(DEBOUNCE) + 1;
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE - 1);
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              capture;
    logic              abort;
    logic [TO_W-1:0]   wait_cnt;

    logic [3:0]        key_s1;
    logic [3:0]        key_s2;
    logic [3:0]        key_db;
    logic [3:0]        key_db_d;
    logic [DB_W-1:0]   db_cnt [4];
    logic [3:0]        key_fall;

    logic              ev_load;
    logic              ev_sel;
    logic              ev_exec;
    logic              ev_view;

    logic [DATA_W-1:0] load_base;
    logic [DATA_W-1:0] load_val;

    // Keys are active-low; reset state is "released" so no event fires out of reset.
    always_ff @(posedge iclock) begin
        if (ireset) begin
            key_s1   <= '1;
            key_s2   <= '1;
            key_db   <= '1;
            key_db_d <= '1;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= DB_RELOAD;
            end
        end else begin
            key_s1   <= ikey;
            key_s2   <= key_s1;
            key_db_d <= key_db;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == key_db[i]) begin
                    db_cnt[i] <= DB_RELOAD;
                end else if (db_cnt[i] == '0) begin
                    key_db[i] <= key_s2[i];
                    db_cnt[i] <= DB_RELOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - DB_W'(1);
                end
            end
        end
    end

    assign key_fall = key_db_d & ~key_db;
    assign ev_load  = key_fall[0];
    assign ev_sel   = key_fall[1];
    assign ev_exec  = key_fall[2];
    assign ev_view  = key_fall[3];

    assign obusy = (state_q != ST_IDLE);

    always_comb begin
        load_base = osel ? oalu_b : oalu_a;
        if (LOAD_MODE == 0) begin
            load_val = {isw, {(DATA_W-SW_W){1'b0}}};
        end else begin
            load_val = (load_base << SW_W) | DATA_W'(isw);
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_exec) begin
                    state_d = ST_ISSUE;
                    accept  = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // done in the same cycle as expiry still completes normally
                if (ialu_done) begin
                    state_d = ST_IDLE;
                    capture = 1'b1;
                end else if (wait_cnt == '0) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclock) begin
        if (ireset) begin
            state_q    <= ST_IDLE;
            wait_cnt   <= '0;
            oalu_start <= 1'b0;
            oalu_ctrl  <= '0;
            oresult    <= '0;
            oflags     <= '0;
            otimeout   <= 1'b0;
        end else begin
            state_q    <= state_d;
            oalu_start <= (state_d == ST_ISSUE);
            if (state_q == ST_ISSUE) begin
                wait_cnt <= TO_RELOAD;
            end else if (state_q == ST_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - TO_W'(1);
            end
            if (accept) begin
                oalu_ctrl <= icontrol;
                otimeout  <= 1'b0;
            end
            if (capture) begin
                oresult <= ialu_result;
                oflags  <= ialu_flags;
            end
            if (abort) begin
                otimeout <= 1'b1;
            end
        end
    end

    // Load uses the osel value from before any simultaneous sel event.
    always_ff @(posedge iclock) begin
        if (ireset) begin
            oalu_a <= '0;
            oalu_b <= '0;
            osel   <= 1'b0;
            oview  <= '0;
            odisp  <= '0;
        end else begin
            if (ev_load && !obusy) begin
                if (osel) begin
                    oalu_b <= load_val;
                end else begin
                    oalu_a <= load_val;
                end
            end
            if (ev_sel) begin
                osel <= ~osel;
            end
            if (ev_view) begin
                oview <= oview + 2'd1;
            end
            case (oview)
                2'd0:    odisp <= oresult;
                2'd1:    odisp <= oalu_a;
                2'd2:    odisp <= oalu_b;
                default: odisp <= {{(DATA_W-6){1'b0}}, otimeout, oflags};
            endcase
        end
    end

endmodule

// File: tb/tb_fpalu_console.sv
// Randomized self-checking bench for fpalu_console; one instance per load mode,
// checked against an operation-level model of the console.

module tb_fpalu_console;

    localparam int DW  = 32;
    localparam int SW  = 10;
    localparam int OW  = 4;
    localparam int DB  = 4;
    localparam int TO  = 8;
    localparam int TO1 = 40;
    localparam int SETTLE = DB + 6;

    logic          CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic          ireset;
    logic [3:0]    key0, key1;
    logic [SW-1:0] sw;
    logic [OW-1:0] ctl;
    logic          done0, done1;
    logic [DW-1:0] res;
    logic [4:0]    flg;

    logic [DW-1:0] a0, b0, result0, disp0, a1, b1, result1, disp1;
    logic [OW-1:0] ctrl0, ctrl1;
    logic [4:0]    flags0, flags1;
    logic [1:0]    view0, view1;
    logic          start0, start1, sel0, sel1, busy0, busy1, tout0, tout1;

    fpalu_console #(.DATA_W(DW), .SW_W(SW), .OP_W(OW), .LOAD_MODE(0),
                    .DEBOUNCE(DB), .TIMEOUT(TO)) dut0 (
        .iclock(CLOCK_50), .ireset(ireset), .ikey(key0), .isw(sw), .icontrol(ctl),
        .oalu_a(a0), .oalu_b(b0), .oalu_ctrl(ctrl0), .oalu_start(start0),
        .ialu_done(done0), .ialu_result(res), .ialu_flags(flg),
        .oresult(result0), .oflags(flags0), .odisp(disp0), .oview(view0),
        .osel(sel0), .obusy(busy0), .otimeout(tout0));

    fpalu_console #(.DATA_W(DW), .SW_W(SW), .OP_W(OW), .LOAD_MODE(1),
                    .DEBOUNCE(DB), .TIMEOUT(TO1)) dut1 (
        .iclock(CLOCK_50), .ireset(ireset), .ikey(key1), .isw(sw), .icontrol(ctl),
        .oalu_a(a1), .oalu_b(b1), .oalu_ctrl(ctrl1), .oalu_start(start1),
        .ialu_done(done1), .ialu_result(res), .ialu_flags(flg),
        .oresult(result1), .oflags(flags1), .odisp(disp1), .oview(view1),
        .osel(sel1), .obusy(busy1), .otimeout(tout1));

    int checks = 0;
    int errors = 0;
    int starts0 = 0;
    int starts1 = 0;

    always @(negedge CLOCK_50) begin
        if (start0 === 1'b1) starts0++;
        if (start1 === 1'b1) starts1++;
    end

    // operation-level model of dut0 (top-aligned loads)
    logic [DW-1:0] m_a, m_b, m_res;
    logic [OW-1:0] m_ctrl;
    logic [4:0]    m_flg;
    logic [1:0]    m_view;
    logic          m_sel, m_to;
    // model of dut1 (shift-in loads)
    logic [DW-1:0] n_a, n_b, n_res;
    logic          n_sel;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_res = '0; m_ctrl = '0; m_flg = '0;
        m_view = '0; m_sel = 1'b0; m_to = 1'b0;
        n_a = '0; n_b = '0; n_res = '0; n_sel = 1'b0;
    endtask

    function automatic logic [31:0] disp_m();
        case (m_view)
            2'd0:    return m_res;
            2'd1:    return m_a;
            2'd2:    return m_b;
            default: return {26'd0, m_to, m_flg};
        endcase
    endfunction

    task automatic check_all0(input string tag);
        check_val({tag, ":a"},     a0, m_a);
        check_val({tag, ":b"},     b0, m_b);
        check_val({tag, ":ctrl"},  32'(ctrl0), 32'(m_ctrl));
        check_val({tag, ":res"},   result0, m_res);
        check_val({tag, ":flags"}, 32'(flags0), 32'(m_flg));
        check_val({tag, ":view"},  32'(view0), 32'(m_view));
        check_val({tag, ":sel"},   32'(sel0), 32'(m_sel));
        check_val({tag, ":tout"},  32'(tout0), 32'(m_to));
        check_val({tag, ":busy"},  32'(busy0), 32'd0);
        check_val({tag, ":start"}, 32'(start0), 32'd0);
        check_val({tag, ":disp"},  disp0, disp_m());
    endtask

    // press (active-low) the keys in mask on dut0 together, then release
    task automatic press0(input logic [3:0] mask);
        key0 = ~mask;
        ticks(SETTLE);
        key0 = 4'hF;
        ticks(SETTLE);
        if (mask[0]) begin
            if (m_sel) m_b = {sw, {(DW-SW){1'b0}}};
            else       m_a = {sw, {(DW-SW){1'b0}}};
        end
        if (mask[1]) m_sel = ~m_sel;
        if (mask[3]) m_view = m_view + 2'd1;
    endtask

    task automatic press1(input logic [3:0] mask);
        key1 = ~mask;
        ticks(SETTLE);
        key1 = 4'hF;
        ticks(SETTLE);
        if (mask[0]) begin
            if (n_sel) n_b = (n_b << SW) | DW'(sw);
            else       n_a = (n_a << SW) | DW'(sw);
        end
        if (mask[1]) n_sel = ~n_sel;
    endtask

    // d = WAIT cycle (1-based) on which done is driven; values above TO never land in WAIT
    task automatic run_exec0(input int d, input logic [31:0] r, input logic [4:0] f,
                             input logic [3:0] c);
        int  s0;
        int  endj;
        bit  seen;
        s0   = starts0;
        seen = 0;
        ctl  = c; res = r; flg = f;
        key0[2] = 1'b0;
        for (int i = 0; i < DB + 10 && !seen; i++) begin
            tick();
            if (start0 === 1'b1) seen = 1;
        end
        check_val("exec_start_seen", 32'(seen), 32'd1);
        key0[2] = 1'b1;
        if (seen) begin
            check_val("issue_busy", 32'(busy0), 32'd1);
            check_val("issue_ctrl", 32'(ctrl0), 32'(c));
            check_val("issue_tout_clear", 32'(tout0), 32'd0);
            endj = (d >= 1 && d <= TO) ? d : TO;
            for (int j = 1; j <= TO + 4; j++) begin
                tick();
                check_val("wait_busy", 32'(busy0), (j <= endj) ? 32'd1 : 32'd0);
                done0 = (j == d);
            end
        end
        done0 = 1'b0;
        ticks(SETTLE);
        check_val("one_start", 32'(starts0 - s0), 32'd1);
        m_ctrl = c;
        if (d >= 1 && d <= TO) begin
            m_res = r; m_flg = f; m_to = 1'b0;
        end else begin
            m_to = 1'b1;
        end
    endtask

    // load and execute attempts during WAIT on dut1 must be dropped
    task automatic lockout1();
        int  s1;
        bit  seen;
        s1   = starts1;
        seen = 0;
        ctl  = 4'h5; res = 32'h1234_5678; flg = 5'b10010;
        key1[2] = 1'b0;
        for (int i = 0; i < DB + 10 && !seen; i++) begin
            tick();
            if (start1 === 1'b1) seen = 1;
        end
        check_val("lock_start_seen", 32'(seen), 32'd1);
        key1[2] = 1'b1;
        sw      = 10'h2A5;
        key1[0] = 1'b0;
        ticks(10);
        key1[0] = 1'b1;
        key1[2] = 1'b0;
        ticks(10);
        key1[2] = 1'b1;
        ticks(8);
        check_val("lock_busy", 32'(busy1), 32'd1);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        ticks(SETTLE);
        n_res = 32'h1234_5678;
        check_val("lock_one_start", 32'(starts1 - s1), 32'd1);
        check_val("lock_a", a1, n_a);
        check_val("lock_b", b1, n_b);
        check_val("lock_res", result1, n_res);
        check_val("lock_idle", 32'(busy1), 32'd0);
    endtask

    initial begin
        int op;
        int d;
        bit seen;
        key0 = 4'hF; key1 = 4'hF; sw = '0; ctl = '0;
        done0 = 1'b0; done1 = 1'b0; res = '0; flg = '0;
        ireset = 1'b1;
        ticks(3);
        ireset = 1'b0;
        tick();
        model_reset();
        check_all0("reset");
        check_val("reset_b1", b1, 32'd0);

        // bouncing load key yields a single load
        sw = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            key0[0] = 1'b0; ticks(2);
            key0[0] = 1'b1; ticks(2);
        end
        key0[0] = 1'b0;
        ticks(10);
        key0[0] = 1'b1;
        ticks(SETTLE);
        m_a = {sw, {(DW-SW){1'b0}}};
        check_val("bounce_a", a0, 32'hFFC0_0000);
        check_all0("bounce");

        // shift-in loads into B on dut1
        press1(4'b0010);
        sw = 10'h001; press1(4'b0001);
        sw = 10'h002; press1(4'b0001);
        sw = 10'h003; press1(4'b0001);
        check_val("shift_b", b1, 32'h0010_0803);
        check_val("shift_b_model", b1, n_b);

        run_exec0(3, 32'h4000_0000, 5'b00001, 4'h2);
        check_all0("handshake");

        run_exec0(99, 32'hAAAA_5555, 5'b11111, 4'h7);
        check_all0("timeout");
        run_exec0(TO, 32'hCAFE_0001, 5'b00110, 4'h3);
        check_all0("done_at_limit");
        run_exec0(TO + 1, 32'hBAD0_0002, 5'b01000, 4'h9);
        check_all0("done_late");

        lockout1();

        sw = 10'h155;
        press0(4'b0011);
        check_all0("load_sel_same");

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 4);
            sw = SW'($urandom_range(0, 1023));
            case (op)
                0: press0(4'b0001);
                1: press0(4'b0010);
                2: press0(4'b1000);
                3: press0(4'b1011);
                default: begin
                    d = ($urandom_range(0, 3) == 0) ? 99 : $urandom_range(1, TO + 2);
                    run_exec0(d, $urandom, 5'($urandom_range(0, 31)),
                              4'($urandom_range(0, 15)));
                end
            endcase
            check_all0("rand");
        end

        // reset while in WAIT, then a late done
        ctl = 4'hE;
        res = 32'hDEAD_BEEF;
        flg = 5'b10101;
        seen = 0;
        key0[2] = 1'b0;
        for (int i = 0; i < DB + 10 && !seen; i++) begin
            tick();
            if (start0 === 1'b1) seen = 1;
        end
        check_val("rstwait_start_seen", 32'(seen), 32'd1);
        key0[2] = 1'b1;
        ticks(2);
        ireset = 1'b1;
        tick();
        model_reset();
        check_val("rstwait_start", 32'(start0), 32'd0);
        check_val("rstwait_busy", 32'(busy0), 32'd0);
        ireset = 1'b0;
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        ticks(SETTLE);
        check_all0("rst_wait");

        for (int i = 0; i < 4; i++) begin
            press0(4'b1000);
            check_all0("view");
        end
        check_val("view_wrap", 32'(view0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
